// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART TX arbiter and the planned RX demux.
// The XON/XOFF codes must match the UART IP's in-band flow control.
package uart_pkg;

  localparam logic [7:0] CHAR_XON     = 8'd17;
  localparam logic [7:0] CHAR_XOFF    = 8'd19;
  localparam logic [7:0] DEF_ESC_CHAR = 8'h7D;
  localparam logic [7:0] DEF_ESC_XOR  = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    ESC2 = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: picks the first set request at or after ptr, wrapping.
// Purely combinational, no backpressure.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] index
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any   = 1'b0;
    index = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        any   = 1'b1;
        index = ($clog2(N))'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of the UART TX channel: header byte per burst, byte-stuffed payload.
// Header one cycle after grant; ri=0 freezes all state and outputs, req_ready follows ri combinationally.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int                     N_REQ       = 4,
  parameter int                     FRAME_WIDTH = 8,
  parameter int                     MAX_BURST   = 16,
  parameter logic [FRAME_WIDTH-1:0] HDR_BASE    = FRAME_WIDTH'(8'hE0),
  parameter logic [FRAME_WIDTH-1:0] ESC_CHAR    = FRAME_WIDTH'(DEF_ESC_CHAR),
  parameter logic [FRAME_WIDTH-1:0] ESC_XOR     = FRAME_WIDTH'(DEF_ESC_XOR)
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*FRAME_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [FRAME_WIDTH-1:0]       din,
  output logic                         si,
  input  logic                         ri,
  output logic [3:0]                   grant_id,
  output logic                         busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t             state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic [CW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [FRAME_WIDTH-1:0] esc_byte_q, esc_byte_d;
  logic                   pick_any;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          next_ptr;
  logic [FRAME_WIDTH-1:0] g_data;
  logic                   g_valid;
  logic                   g_esc;
  logic                   pop;
  logic [CW-1:0]          cnt_inc;

  // Header range test uses a wrapped offset so HDR_BASE near the top of the byte space still works.
  function automatic logic is_esc(input logic [FRAME_WIDTH-1:0] b);
    logic [FRAME_WIDTH-1:0] off;
    off = b - HDR_BASE;
    return (b == FRAME_WIDTH'(CHAR_XON)) || (b == FRAME_WIDTH'(CHAR_XOFF)) ||
           (b == ESC_CHAR) || (int'(off) < N_REQ);
  endfunction

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .any   (pick_any),
    .index (pick_idx)
  );

  assign g_data   = req_data[int'(grant_q) * FRAME_WIDTH +: FRAME_WIDTH];
  assign g_valid  = req_valid[grant_q];
  assign g_esc    = is_esc(g_data);
  assign next_ptr = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
  assign cnt_inc  = burst_cnt_q + CW'(1);
  assign pop      = ri && (((state_q == DATA) && g_valid && !g_esc) || (state_q == ESC2));
  assign grant_id = 4'(grant_q);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    esc_byte_d  = esc_byte_q;
    si          = 1'b0;
    din         = '0;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        si  = 1'b1;
        din = HDR_BASE + FRAME_WIDTH'(grant_q);
        if (ri) begin
          state_d     = DATA;
          burst_cnt_d = '0;
        end
      end
      DATA: begin
        if (!g_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (g_esc) begin
          si  = 1'b1;
          din = ESC_CHAR;
          if (ri) begin
            esc_byte_d = g_data ^ ESC_XOR;
            state_d    = ESC2;
          end
        end else begin
          si                 = 1'b1;
          din                = g_data;
          req_ready[grant_q] = ri;
        end
      end
      ESC2: begin
        si                 = 1'b1;
        din                = esc_byte_q;
        req_ready[grant_q] = ri;
      end
      default: state_d = IDLE;
    endcase
    // Both payload paths end in the same pop bookkeeping.
    if (pop) begin
      burst_cnt_d = cnt_inc;
      if (cnt_inc == CW'(MAX_BURST)) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end else begin
        state_d = DATA;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      esc_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      esc_byte_q  <= esc_byte_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the DUT, the UART-side
// byte stream and pop counts are compared against a burst-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 2;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  din;
  logic        si;
  logic        ri;
  logic [3:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(
    .N_REQ(N), .FRAME_WIDTH(8), .MAX_BURST(MB),
    .HDR_BASE(8'hE0), .ESC_CHAR(8'h7D), .ESC_XOR(8'h20)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .din(din), .si(si), .ri(ri), .grant_id(grant_id), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] src_q [N][$];
  logic [7:0] mq [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         pop_cnt [N];
  int         exp_pops [N];
  int         stray_cnt = 0;
  logic [3:0] pop_now = '0;
  int         mdl_ptr = 0;
  bit         use_q = 1'b0;

  always @(negedge sys_clk) begin
    pop_now = req_valid & req_ready & {4{!reset}};
    if (!reset) begin
      if (si && ri) obs_q.push_back(din);
      for (int i = 0; i < N; i++) if (pop_now[i]) pop_cnt[i]++;
      if ((req_ready & ~(4'b0001 << grant_id)) != 4'b0000) stray_cnt++;
    end
  end

  task automatic step(input bit ri_v);
    @(posedge sys_clk);
    #1;
    if (use_q) begin
      for (int i = 0; i < N; i++) begin
        if (pop_now[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i] = (src_q[i].size() > 0);
        req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
    ri = ri_v;
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return (b == 8'd17) || (b == 8'd19) || (b == 8'h7D) || (b >= 8'hE0 && b <= 8'hE3);
  endfunction

  // Burst-level model: whole bursts are generated from queue contents and the round-robin pointer.
  task automatic predict();
    int g;
    int n;
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      mq[i] = src_q[i];
      exp_pops[i] = src_q[i].size();
      pop_cnt[i] = 0;
    end
    forever begin
      g = -1;
      for (int off = N - 1; off >= 0; off--)
        if (mq[(mdl_ptr + off) % N].size() > 0) g = (mdl_ptr + off) % N;
      if (g < 0) break;
      exp_q.push_back(8'hE0 + 8'(g));
      n = 0;
      while (n < MB && mq[g].size() > 0) begin
        b = mq[g].pop_front();
        if (is_special(b)) begin
          exp_q.push_back(8'h7D);
          exp_q.push_back(b ^ 8'h20);
        end else begin
          exp_q.push_back(b);
        end
        n++;
      end
      mdl_ptr = (g + 1) % N;
    end
    obs_q.delete();
    stray_cnt = 0;
  endtask

  function automatic int first_diff();
    int len;
    len = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < len; i++) begin
      if (i >= obs_q.size() || i >= exp_q.size()) return i;
      if (obs_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic int q_at(input bit obs, input int i);
    if (obs) return (i >= 0 && i < obs_q.size()) ? int'(obs_q[i]) : -1;
    return (i >= 0 && i < exp_q.size()) ? int'(exp_q[i]) : -1;
  endfunction

  function automatic int pop_diff();
    for (int i = 0; i < N; i++) if (pop_cnt[i] != exp_pops[i]) return i;
    return -1;
  endfunction

  task automatic run_queues(input int ri_pct, input string name);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    use_q = 1'b1;
    while (!done && cyc < 3000) begin
      step($urandom_range(99) < ri_pct);
      cyc++;
      done = !busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 1'b0;
    end
    step(1'b1);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s drain: still busy after %0d cycles, required idle", name, cyc);
    end
  endtask

  task automatic check_traffic(input string name);
    int d;
    d = first_diff();
    vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL %s stream byte %0d: got %0h required %0h (len %0d, required len %0d; ffffffff=none)",
               name, d, q_at(1'b1, d), q_at(1'b0, d), obs_q.size(), exp_q.size());
    end
    d = pop_diff();
    vectors++;
    if (d >= 0) begin
      miscompares++;
      $display("FAIL %s pops req %0d: got %0d required %0d", name, d, pop_cnt[d], exp_pops[d]);
    end
    vectors++;
    if (stray_cnt !== 0) begin
      miscompares++;
      $display("FAIL %s stray req_ready: got %0d cycles required 0", name, stray_cnt);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle after burst: busy got %b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    use_q = 1'b0;
    reset = 1'b1;
    ri = 1'b1;
    req_valid = 4'hF;
    req_data = $urandom;
    repeat (3) step(1'b1);
    vectors++;
    if (si !== 1'b0) begin miscompares++; $display("FAIL reset si: got %b required 0", si); end
    vectors++;
    if (din !== 8'h00) begin miscompares++; $display("FAIL reset din: got %h required 00", din); end
    vectors++;
    if (req_ready !== 4'h0) begin miscompares++; $display("FAIL reset req_ready: got %b required 0000", req_ready); end
    vectors++;
    if (grant_id !== 4'h0) begin miscompares++; $display("FAIL reset grant_id: got %0d required 0", grant_id); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b required 0", busy); end
    req_valid = 4'h0;
    reset = 1'b0;
    mdl_ptr = 0;
    step(1'b1);
  endtask

  task automatic test_single();
    src_q[2] = '{8'h41, 8'h42};
    predict();
    run_queues(100, "single");
    check_traffic("single");
  endtask

  task automatic test_all_valid();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++) src_q[i].push_back(8'($urandom_range(8'h20, 8'h5F)));
    predict();
    run_queues(100, "all_valid");
    check_traffic("all_valid");
  endtask

  task automatic test_escape();
    src_q[0] = '{8'h11, 8'h13, 8'hE1};
    predict();
    run_queues(100, "escape");
    check_traffic("escape");
  endtask

  task automatic test_stall();
    logic [7:0] held;
    int cyc;
    src_q[1] = '{8'h11, 8'h55};
    predict();
    use_q = 1'b1;
    cyc = 0;
    step(1'b0);
    while (!si && cyc < 20) begin step(1'b0); cyc++; end
    vectors++;
    if (!si) begin miscompares++; $display("FAIL stall header: si got 0 required 1"); end
    held = din;
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      vectors++;
      if (si !== 1'b1 || din !== held || req_ready !== 4'h0 || pop_cnt[1] !== 0) begin
        miscompares++;
        $display("FAIL stall hdr hold %0d: si %b din %h rdy %b pops %0d, required 1 %h 0000 0",
                 k, si, din, req_ready, pop_cnt[1], held);
      end
    end
    step(1'b1);
    step(1'b1);
    step(1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      vectors++;
      if (si !== 1'b1 || din !== (8'h11 ^ 8'h20) || req_ready !== 4'h0 || pop_cnt[1] !== 0) begin
        miscompares++;
        $display("FAIL stall esc2 hold %0d: si %b din %h rdy %b pops %0d, required 1 31 0000 0",
                 k, si, din, req_ready, pop_cnt[1]);
      end
    end
    run_queues(100, "stall");
    check_traffic("stall");
  endtask

  task automatic test_hdr_only();
    predict();
    use_q = 1'b0;
    req_valid = 4'b0010;
    req_data[15:8] = 8'h22;
    step(1'b1);
    req_valid = 4'b0000;
    repeat (4) step(1'b1);
    exp_q = '{8'hE1};
    for (int i = 0; i < N; i++) exp_pops[i] = 0;
    mdl_ptr = 2;
    check_traffic("hdr_only");
    src_q[1] = '{8'h33};
    src_q[2] = '{8'h44};
    predict();
    run_queues(100, "hdr_only_next");
    check_traffic("hdr_only_next");
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int k = 0; k < 6; k++) src_q[2].push_back(8'($urandom_range(8'h20, 8'h5F)));
    predict();
    use_q = 1'b1;
    cyc = 0;
    while (obs_q.size() < 2 && cyc < 50) begin step(1'b1); cyc++; end
    ri = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    step(1'b0);
    vectors++;
    if (si !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid: si %b busy %b rdy %b, required 0 0 0000", si, busy, req_ready);
    end
    reset = 1'b0;
    mdl_ptr = 0;
    step(1'b0);
    src_q[1] = '{8'(8'h60 + $urandom_range(15))};
    src_q[3] = '{8'(8'h70 + $urandom_range(12))};
    predict();
    run_queues(100, "reset_mid_next");
    check_traffic("reset_mid_next");
  endtask

  task automatic test_random();
    logic [7:0] specials [10];
    specials = '{8'd17, 8'd19, 8'h7D, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hDF, 8'h5D};
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(0, 5);
        for (int k = 0; k < len; k++)
          src_q[i].push_back(($urandom_range(1) == 1) ? specials[$urandom_range(9)] : 8'($urandom));
      end
      predict();
      run_queues(40 + $urandom_range(60), "random");
      check_traffic("random");
    end
  endtask

  initial begin
    reset = 1'b1;
    ri = 1'b0;
    req_valid = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_escape();
    test_stall();
    test_hdr_only();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
